// File: rtl/seq_det_pkg.sv
// Shared defaults for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int DEF_LEN = 6;
  localparam logic [DEF_LEN-1:0] DEF_PATTERN = 6'b111010;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating event counter with a sticky saturation flag; clear wins over count but keeps a coincident event.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_inc;

  assign cnt_inc = cnt + W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
      sat <= 1'b0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt_inc;
      if (&cnt_inc) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial LEN-bit pattern detector with runtime pattern reload, overlap control,
// Mealy or registered match pulse and a saturating hit counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int              LEN            = DEF_LEN,
  parameter logic [LEN-1:0]  PATTERN        = LEN'(DEF_PATTERN),
  parameter int              CNT_W          = DEF_CNT_W,
  parameter bit              REGISTERED_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FILL_W = $clog2(LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

  // Stream qualifier: x is consumed on a cycle where x_valid is high and no
  // pattern load is in progress; there is no back-pressure, every such bit is taken.
  logic [LEN-1:0]    pat_reg;
  logic [LEN-2:0]    hist;    // only the newest LEN-1 bits ever take part in a compare
  logic [FILL_W-1:0] fill;
  logic [LEN-1:0]    shifted;
  logic              acc;
  logic              hit;

  assign acc     = x_valid & ~pat_load;
  assign shifted = {hist, x};
  assign hit     = acc & (fill == FILL_MAX) & (shifted == pat_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_reg <= PATTERN;
      hist    <= '0;
      fill    <= '0;
    end else if (pat_load) begin
      pat_reg <= pat_in;
      hist    <= '0;
      fill    <= '0;
    end else if (acc) begin
      if (hit && !overlap) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= shifted[LEN-2:0];
        if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
      end
    end
  end

  generate
    if (REGISTERED_OUT) begin : g_reg_out
      logic y_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) y_q <= 1'b0;
        else     y_q <= hit;
      end
      assign y = y_q;
    end else begin : g_mealy_out
      assign y = hit;
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (cnt_clr),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: four builds (default Mealy, LEN=3, registered, CNT_W=2)
// share one stimulus stream; each scenario resets first and checks the build it targets.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [5:0] pat_in6 = 6'b111010;
  logic [2:0] pat_in3 = 3'b000;
  logic       cnt_clr = 1'b0;

  logic       a_y, b_y, c_y, d_y;
  logic [7:0] a_cnt, b_cnt, c_cnt;
  logic [1:0] d_cnt;
  logic       a_sat, b_sat, c_sat, d_sat;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_param dut_a (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in6), .cnt_clr(cnt_clr),
    .y(a_y), .match_cnt(a_cnt), .cnt_sat(a_sat)
  );

  seq_detector_param #(.LEN(3), .PATTERN(3'b000)) dut_b (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in3), .cnt_clr(cnt_clr),
    .y(b_y), .match_cnt(b_cnt), .cnt_sat(b_sat)
  );

  seq_detector_param #(.REGISTERED_OUT(1'b1)) dut_c (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in6), .cnt_clr(cnt_clr),
    .y(c_y), .match_cnt(c_cnt), .cnt_sat(c_sat)
  );

  seq_detector_param #(.CNT_W(2)) dut_d (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in6), .cnt_clr(cnt_clr),
    .y(d_y), .match_cnt(d_cnt), .cnt_sat(d_sat)
  );

  // Driver: present one bit in the low phase; returns 1 time unit later so the caller samples away from posedge.
  task automatic drive_bit(input logic b, input logic v);
    @(negedge clk);
    x        = b;
    x_valid  = v;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    x_valid = 1'b0;
    pat_load = 1'b0;
    cnt_clr = 1'b0;
    overlap = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    x_valid = 1'b0;
    #1;
    n_vec++;
    if ({a_y, b_y, c_y, d_y} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_y got %b want 0000", {a_y, b_y, c_y, d_y});
    end
    n_vec++;
    if ({a_cnt, b_cnt, c_cnt, d_cnt} !== 26'd0 || {a_sat, b_sat, c_sat, d_sat} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_cnt got cnt=%h sat=%b want 0", {a_cnt, b_cnt, c_cnt, d_cnt}, {a_sat, b_sat, c_sat, d_sat});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_mealy();
    logic [7:0] s;
    logic [7:0] e;
    s = 8'b01110100;
    e = 8'b00000010;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      drive_bit(s[i], 1'b1);
      n_vec++;
      if (a_y !== e[i]) begin
        n_err++;
        $display("FAIL basic_y[%0d] got %b want %b", 7 - i, a_y, e[i]);
      end
    end
    drive_bit(1'b0, 1'b0);
    n_vec++;
    if (a_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL basic_cnt got %0d want 1", a_cnt);
    end
  endtask

  task automatic test_overlap();
    logic [4:0] s;
    logic [4:0] e;
    s = 5'b10101;
    for (int ov = 1; ov >= 0; ov--) begin
      e = (ov == 1) ? 5'b00101 : 5'b00100;
      do_reset();
      overlap = ov[0];
      @(negedge clk);
      pat_load = 1'b1;
      pat_in3 = 3'b101;
      x = 1'b1;
      x_valid = 1'b1;
      #1;
      n_vec++;
      if (b_y !== 1'b0) begin
        n_err++;
        $display("FAIL load_cycle_y ov=%0d got %b want 0", ov, b_y);
      end
      for (int i = 4; i >= 0; i--) begin
        drive_bit(s[i], 1'b1);
        n_vec++;
        if (b_y !== e[i]) begin
          n_err++;
          $display("FAIL overlap_y ov=%0d bit%0d got %b want %b", ov, 5 - i, b_y, e[i]);
        end
      end
      drive_bit(1'b0, 1'b0);
      n_vec++;
      if (b_cnt !== ((ov == 1) ? 8'd2 : 8'd1)) begin
        n_err++;
        $display("FAIL overlap_cnt ov=%0d got %0d want %0d", ov, b_cnt, (ov == 1) ? 2 : 1);
      end
    end
  endtask

  task automatic test_valid_gap();
    logic [3:0] s;
    s = 4'b1110;
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      drive_bit(s[i], 1'b1);
      n_vec++;
      if (a_y !== 1'b0) begin
        n_err++;
        $display("FAIL gap_pre_y[%0d] got %b want 0", 3 - i, a_y);
      end
    end
    for (int g = 0; g < 5; g++) begin
      drive_bit(g[0], 1'b0);
      n_vec++;
      if (a_y !== 1'b0) begin
        n_err++;
        $display("FAIL gap_idle_y[%0d] got %b want 0", g, a_y);
      end
    end
    drive_bit(1'b1, 1'b1);
    n_vec++;
    if (a_y !== 1'b0) begin
      n_err++;
      $display("FAIL gap_post_y got %b want 0", a_y);
    end
    drive_bit(1'b0, 1'b1);
    n_vec++;
    if (a_y !== 1'b1) begin
      n_err++;
      $display("FAIL gap_last_y got %b want 1", a_y);
    end
  endtask

  task automatic test_registered();
    logic [5:0] s;
    s = 6'b111010;
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      drive_bit(s[i], 1'b1);
      n_vec++;
      if (c_y !== 1'b0) begin
        n_err++;
        $display("FAIL reg_y bit%0d got %b want 0", 5 - i, c_y);
      end
    end
    drive_bit(1'b0, 1'b0);
    n_vec++;
    if (c_y !== 1'b1) begin
      n_err++;
      $display("FAIL reg_pulse got %b want 1", c_y);
    end
    drive_bit(1'b0, 1'b0);
    n_vec++;
    if (c_y !== 1'b0) begin
      n_err++;
      $display("FAIL reg_width got %b want 0", c_y);
    end
  endtask

  task automatic test_saturation();
    logic [5:0] s;
    s = 6'b111010;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int i = 5; i >= 0; i--) drive_bit(s[i], 1'b1);
      drive_bit(1'b0, 1'b0);
      n_vec++;
      if (d_cnt !== ((r >= 2) ? 2'd3 : 2'(r + 1)) || d_sat !== (r >= 2)) begin
        n_err++;
        $display("FAIL sat_hit%0d got cnt=%0d sat=%b want cnt=%0d sat=%b",
                 r + 1, d_cnt, d_sat, (r >= 2) ? 3 : r + 1, r >= 2);
      end
    end
    for (int i = 5; i >= 1; i--) drive_bit(s[i], 1'b1);
    drive_bit(s[0], 1'b1);
    cnt_clr = 1'b1;
    n_vec++;
    if (d_y !== 1'b1) begin
      n_err++;
      $display("FAIL clr_hit_y got %b want 1", d_y);
    end
    drive_bit(1'b0, 1'b0);
    n_vec++;
    if (d_cnt !== 2'd1 || d_sat !== 1'b0) begin
      n_err++;
      $display("FAIL clr_hit_cnt got cnt=%0d sat=%b want cnt=1 sat=0", d_cnt, d_sat);
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] s;
    s = 6'b111010;
    do_reset();
    for (int i = 5; i >= 0; i--) drive_bit(s[i], 1'b1);
    for (int i = 5; i >= 1; i--) drive_bit(s[i], 1'b1);
    drive_bit(1'b0, 1'b1);
    n_vec++;
    if (a_y !== 1'b1 || a_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL arst_pre got y=%b cnt=%0d want y=1 cnt=1", a_y, a_cnt);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (a_y !== 1'b0 || a_cnt !== 8'd0 || a_sat !== 1'b0) begin
      n_err++;
      $display("FAIL arst_now got y=%b cnt=%0d sat=%b want 0 0 0", a_y, a_cnt, a_sat);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (a_y !== 1'b0) begin
      n_err++;
      $display("FAIL arst_release_y got %b want 0", a_y);
    end
    drive_bit(1'b0, 1'b1);
    n_vec++;
    if (a_y !== 1'b0 || a_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL arst_after got y=%b cnt=%0d want y=0 cnt=0", a_y, a_cnt);
    end
  endtask

  task automatic test_pat_load();
    logic [3:0] pre;
    logic [7:0] post;
    logic [7:0] e;
    pre  = 4'b1110;
    post = 8'b10010101;
    e    = 8'b00000001;
    do_reset();
    for (int i = 3; i >= 0; i--) drive_bit(pre[i], 1'b1);
    @(negedge clk);
    pat_load = 1'b1;
    pat_in6 = 6'b010101;
    x = 1'b1;
    x_valid = 1'b1;
    #1;
    n_vec++;
    if (a_y !== 1'b0) begin
      n_err++;
      $display("FAIL load_y got %b want 0", a_y);
    end
    for (int i = 7; i >= 0; i--) begin
      drive_bit(post[i], 1'b1);
      n_vec++;
      if (a_y !== e[i]) begin
        n_err++;
        $display("FAIL newpat_y bit%0d got %b want %b", 7 - i, a_y, e[i]);
      end
    end
    drive_bit(1'b0, 1'b0);
    n_vec++;
    if (a_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL newpat_cnt got %0d want 1", a_cnt);
    end
    pat_in6 = 6'b111010;
  endtask

  initial begin
    test_reset();
    test_basic_mealy();
    test_overlap();
    test_valid_gap();
    test_registered();
    test_saturation();
    test_async_reset();
    test_pat_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
